// File: rtl/posit_packer_pkg.sv
// Shared types and constants for the posit packer: FSM states, default geometry,
// and the maxpos/minpos/NaR bit patterns as constant functions.
package posit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REGIME = 3'd1,
    ST_EXP    = 3'd2,
    ST_FRAC   = 3'd3,
    ST_FINAL  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam int DEF_BITS = 32;
  localparam int DEF_ES   = 3;

  // Patterns are built 64 bits wide; callers cast down to their posit width.
  function automatic logic [63:0] posit_maxpos(input int bits);
    return (64'd1 << (bits - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] posit_minpos(input int bits);
    return (bits > 1) ? 64'd1 : 64'd0;
  endfunction

  function automatic logic [63:0] posit_nar(input int bits);
    return 64'd1 << (bits - 1);
  endfunction

endpackage

// File: rtl/posit_packer_round.sv
// Combinational finishing stage: optional round-to-nearest-even, clamp, minpos
// forcing, sign negation and special-value selection. POSIT_PACKER_ROUND_EN enables rounding.
module posit_round
  import posit_pkg::*;
#(
  parameter int BITS = DEF_BITS
) (
`ifdef POSIT_PACKER_ROUND_EN
  input  logic            i_guard,
  input  logic            i_sticky,
`endif
  input  logic [BITS-2:0] i_mag,
  input  logic            i_sign,
  input  logic            i_zero,
  input  logic            i_nar,
  input  logic            i_clamp_max,
  input  logic            i_clamp_min,
  output logic [BITS-1:0] o_data
);

  localparam logic [BITS-2:0] MAG_MAX = (BITS-1)'(posit_maxpos(BITS));
  localparam logic [BITS-2:0] MAG_MIN = (BITS-1)'(posit_minpos(BITS));
  localparam logic [BITS-1:0] NAR     = BITS'(posit_nar(BITS));
  localparam logic [BITS-1:0] ONE     = BITS'(1);

  logic [BITS-2:0] w_mag;
  logic [BITS-1:0] w_pos;
  logic [BITS-1:0] w_val;

  // Magnitude finishing: round, clamp, then keep nonzero operands off zero.
  always_comb begin
    w_mag = i_mag;
`ifdef POSIT_PACKER_ROUND_EN
    if (i_guard && (i_sticky || i_mag[0]) && (i_mag != MAG_MAX)) begin
      w_mag = i_mag + MAG_MIN;
    end else begin
      w_mag = i_mag;
    end
`endif
    if (i_clamp_max) begin
      w_mag = MAG_MAX;
    end else if (i_clamp_min) begin
      w_mag = MAG_MIN;
    end else if (w_mag == '0) begin
      w_mag = MAG_MIN;
    end else begin
      w_mag = w_mag;
    end
  end

  // Sign application and special-value override (NaR beats zero).
  always_comb begin
    w_pos  = {1'b0, w_mag};
    w_val  = i_sign ? (~w_pos + ONE) : w_pos;
    o_data = w_val;
    if (i_nar) begin
      o_data = NAR;
    end else if (i_zero) begin
      o_data = '0;
    end else begin
      o_data = w_val;
    end
  end

endmodule

// File: rtl/posit_packer.sv
// Bit-serial posit packer: emits regime, exponent and fraction one magnitude bit per
// cycle, then finishes in posit_round. POSIT_PACKER_ROUND_EN enables rounding.
module posit_packer
  import posit_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int ES   = DEF_ES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_sign,
  input  logic            in_zero,
  input  logic            in_nar,
  input  logic [BITS-1:0] in_seed,
  input  logic [ES-1:0]   in_exp,
  input  logic [BITS-1:0] in_frac,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data
);

  localparam int CW = $clog2(BITS) + 1;
  localparam int EW = $clog2(ES + 1);
  localparam logic signed [BITS-1:0] K_MAX = BITS'(BITS - 2);
  localparam logic signed [BITS-1:0] K_MIN = BITS'(-(BITS - 1));

  state_t          r_state;
  state_t          w_next;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [BITS-1:0] r_out_data;
  logic [CW-1:0]   r_pos;
  logic [BITS-2:0] r_mag;
  logic            r_v;
  logic [CW-1:0]   r_run;
  logic [ES-1:0]   r_exp;
  logic [EW-1:0]   r_ecnt;
  logic [BITS-1:0] r_frac;
  logic            r_sign;
  logic            r_zero;
  logic            r_nar;
  logic            r_cmax;
  logic            r_cmin;
  logic            r_hold;
`ifdef POSIT_PACKER_ROUND_EN
  logic            r_term;
`endif

  logic            w_accept;
  logic            w_special;
  logic            w_retire;
  logic            w_last;
  logic            w_bit;
  logic            w_cmax;
  logic            w_cmin;
  logic [CW-1:0]   w_k_lo;
  logic [CW-1:0]   w_run_init;
  logic [BITS-1:0] w_round;

  assign w_accept  = in_valid & r_in_ready;
  assign w_special = in_nar | in_zero;
  assign w_retire  = r_out_valid & out_ready;
  assign w_last    = (r_pos == CW'(0));
  assign w_cmax    = ($signed(in_seed) >= K_MAX);
  assign w_cmin    = ($signed(in_seed) <= K_MIN);
  assign w_k_lo    = in_seed[CW-1:0];

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Regime run length; unclamped k is small enough to live in CW bits.
  always_comb begin
    w_run_init = CW'(0);
    if (w_cmax || w_cmin) begin
      w_run_init = CW'(BITS);
    end else if (!in_seed[BITS-1]) begin
      w_run_init = w_k_lo + CW'(1);
    end else begin
      w_run_init = CW'(0) - w_k_lo;
    end
  end

  // Next-state and emitted-bit selection.
  always_comb begin
    w_next = r_state;
    w_bit  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = w_special ? ST_FINAL : ST_REGIME;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_REGIME: begin
        w_bit = (r_run != CW'(0)) ? r_v : ~r_v;
        if (w_last) begin
          w_next = ST_FINAL;
        end else if (r_run == CW'(0)) begin
          w_next = ST_EXP;
        end else begin
          w_next = ST_REGIME;
        end
      end
      ST_EXP: begin
        w_bit = r_exp[ES-1];
        if (w_last) begin
          w_next = ST_FINAL;
        end else if (r_ecnt == EW'(1)) begin
          w_next = ST_FRAC;
        end else begin
          w_next = ST_EXP;
        end
      end
      ST_FRAC: begin
        w_bit = r_frac[BITS-1];
        if (w_last) begin
          w_next = ST_FINAL;
        end else begin
          w_next = ST_FRAC;
        end
      end
      ST_FINAL: begin
        // Specials dwell one extra cycle here for a fixed two-cycle latency.
        if (r_hold) begin
          w_next = ST_FINAL;
        end else begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (w_retire) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_DONE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State register with handshake flags decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == ST_IDLE);
      r_out_valid <= (w_next == ST_DONE);
    end
  end

  // Operand capture, serial emission and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
      r_pos      <= '0;
      r_mag      <= '0;
      r_v        <= 1'b0;
      r_run      <= '0;
      r_exp      <= '0;
      r_ecnt     <= '0;
      r_frac     <= '0;
      r_sign     <= 1'b0;
      r_zero     <= 1'b0;
      r_nar      <= 1'b0;
      r_cmax     <= 1'b0;
      r_cmin     <= 1'b0;
      r_hold     <= 1'b0;
`ifdef POSIT_PACKER_ROUND_EN
      r_term     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_pos  <= CW'(BITS - 2);
            r_mag  <= '0;
            r_v    <= ~in_seed[BITS-1];
            r_run  <= w_run_init;
            r_exp  <= in_exp;
            r_ecnt <= EW'(ES);
            r_frac <= in_frac;
            r_sign <= in_sign;
            r_zero <= in_zero;
            r_nar  <= in_nar;
            r_cmax <= w_cmax;
            r_cmin <= w_cmin;
            r_hold <= w_special;
`ifdef POSIT_PACKER_ROUND_EN
            r_term <= 1'b1;
`endif
          end
        end
        ST_REGIME: begin
          r_mag <= {r_mag[BITS-3:0], w_bit};
          r_pos <= r_pos - CW'(1);
          if (r_run != CW'(0)) begin
            r_run <= r_run - CW'(1);
          end else begin
`ifdef POSIT_PACKER_ROUND_EN
            r_term <= 1'b0;
`else
            r_run <= r_run;
`endif
          end
        end
        ST_EXP: begin
          r_mag  <= {r_mag[BITS-3:0], w_bit};
          r_pos  <= r_pos - CW'(1);
          r_exp  <= r_exp << 1;
          r_ecnt <= r_ecnt - EW'(1);
        end
        ST_FRAC: begin
          r_mag  <= {r_mag[BITS-3:0], w_bit};
          r_pos  <= r_pos - CW'(1);
          r_frac <= r_frac << 1;
        end
        ST_FINAL: begin
          r_hold <= 1'b0;
          if (w_next == ST_DONE) begin
            r_out_data <= w_round;
          end
        end
        ST_DONE: begin
          r_hold <= 1'b0;
        end
        default: begin
          r_hold <= 1'b0;
        end
      endcase
    end
  end

`ifdef POSIT_PACKER_ROUND_EN
  logic          w_guard;
  logic          w_sticky;
  logic [ES-1:0] w_exp_tail;

  assign w_exp_tail = r_exp << 1;

  // Guard is the first bit that was not emitted; sticky ORs everything behind it.
  always_comb begin
    w_guard  = 1'b0;
    w_sticky = 1'b0;
    if (r_run != CW'(0)) begin
      w_guard  = r_v;
      w_sticky = ((r_run > CW'(1)) & r_v) | (r_term & ~r_v) | (|r_exp) | (|r_frac);
    end else if (r_term) begin
      w_guard  = ~r_v;
      w_sticky = (|r_exp) | (|r_frac);
    end else if (r_ecnt != EW'(0)) begin
      w_guard  = r_exp[ES-1];
      w_sticky = (|w_exp_tail) | (|r_frac);
    end else begin
      w_guard  = r_frac[BITS-1];
      w_sticky = |r_frac[BITS-2:0];
    end
  end
`endif

  posit_round #(
    .BITS(BITS)
  ) u_round (
`ifdef POSIT_PACKER_ROUND_EN
    .i_guard     (w_guard),
    .i_sticky    (w_sticky),
`endif
    .i_mag       (r_mag),
    .i_sign      (r_sign),
    .i_zero      (r_zero),
    .i_nar       (r_nar),
    .i_clamp_max (r_cmax),
    .i_clamp_min (r_cmin),
    .o_data      (w_round)
  );

endmodule

// File: tb/tb_posit_packer.sv
// Self-checking bench for posit_packer at BITS=8, ES=1: directed vector table,
// hand-written handshake/reset sequences, and random operands against a stream model.
module tb_posit_packer;

  localparam int BITS = 8;
  localparam int ES   = 1;

`ifdef POSIT_PACKER_ROUND_EN
  localparam logic [7:0] RND_A = 8'h42;
  localparam logic [7:0] RND_B = 8'h60;
`else
  localparam logic [7:0] RND_A = 8'h41;
  localparam logic [7:0] RND_B = 8'h5F;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic            in_sign;
  logic            in_zero;
  logic            in_nar;
  logic [BITS-1:0] in_seed;
  logic [ES-1:0]   in_exp;
  logic [BITS-1:0] in_frac;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic       s;
    logic       z;
    logic       n;
    int         k;
    int         e;
    int         f;
    logic [7:0] exp_d;
    int         exp_lat;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  posit_packer #(
    .BITS(BITS),
    .ES  (ES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sign  (in_sign),
    .in_zero  (in_zero),
    .in_nar   (in_nar),
    .in_seed  (in_seed),
    .in_exp   (in_exp),
    .in_frac  (in_frac),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference: build the full regime/exponent/fraction bit stream, keep the top
  // BITS-1 bits, then round/clamp/negate with plain integer arithmetic.
  function automatic logic [7:0] ref_pack(input logic s, input logic z, input logic n,
                                          input int k, input int e, input int f);
    bit stream[$];
    int m;
    if (n) return 8'h80;
    if (z) return 8'h00;
    if (k >= 0) begin
      for (int i = 0; i < k + 1; i++) stream.push_back(1'b1);
      stream.push_back(1'b0);
    end else begin
      for (int i = 0; i < -k; i++) stream.push_back(1'b0);
      stream.push_back(1'b1);
    end
    for (int i = ES - 1; i >= 0; i--) stream.push_back(bit'((e >> i) & 1));
    for (int i = BITS - 1; i >= 0; i--) stream.push_back(bit'((f >> i) & 1));
    m = 0;
    for (int i = 0; i < BITS - 1; i++) m = m * 2 + int'(stream[i]);
    if (k >= BITS - 2) begin
      m = (1 << (BITS - 1)) - 1;
    end else if (k <= -(BITS - 1)) begin
      m = 0;
    end else begin
`ifdef POSIT_PACKER_ROUND_EN
      bit g;
      bit st;
      g  = stream[BITS - 1];
      st = 1'b0;
      for (int i = BITS; i < stream.size(); i++) st |= stream[i];
      if (g && (st || (m % 2 == 1)) && (m != (1 << (BITS - 1)) - 1)) m++;
`endif
    end
    if (m == 0) m = 1;
    if (s) m = (1 << BITS) - m;
    return 8'(m);
  endfunction

  task automatic set_op(input logic s, input logic z, input logic n, input int k,
                        input int e, input int f);
    in_sign = s;
    in_zero = z;
    in_nar  = n;
    in_seed = BITS'(k);
    in_exp  = ES'(e);
    in_frac = BITS'(f);
  endtask

  // One full transaction; called #1 after a rising edge with the DUT idle.
  task automatic pack(input logic s, input logic z, input logic n, input int k,
                      input int e, input int f, output logic [7:0] d, output int lat);
    int w;
    set_op(s, z, n, k, e, f);
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    d = out_data;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic add_vec(input string name, input logic s, input logic z, input logic n,
                         input int k, input int e, input int f, input logic [7:0] d,
                         input int lat);
    vec_t v;
    v.name = name; v.s = s; v.z = z; v.n = n; v.k = k; v.e = e; v.f = f;
    v.exp_d = d; v.exp_lat = lat;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] prev;
    int         lat;
    int         hits;
    logic       s, z, n;
    int         k, e, f;

    add_vec("basic",      1'b0, 1'b0, 1'b0,  0, 1, 8'h80, 8'h58, 8);
    add_vec("neg_k",      1'b0, 1'b0, 1'b0, -2, 0, 8'h00, 8'h10, 8);
    add_vec("signed",     1'b1, 1'b0, 1'b0,  0, 1, 8'h80, 8'hA8, 8);
    add_vec("clamp_hi",   1'b0, 1'b0, 1'b0,  9, 0, 8'h00, 8'h7F, 8);
    add_vec("clamp_lo",   1'b0, 1'b0, 1'b0, -9, 0, 8'h00, 8'h01, 8);
    add_vec("maxpos_k6",  1'b0, 1'b0, 1'b0,  6, 1, 8'hFF, 8'h7F, 8);
    add_vec("minpos_k-7", 1'b0, 1'b0, 1'b0, -7, 1, 8'hFF, 8'h01, 8);
    add_vec("neg_maxpos", 1'b1, 1'b0, 1'b0,  9, 0, 8'h00, 8'h81, 8);
    add_vec("zero",       1'b0, 1'b1, 1'b0,  3, 1, 8'hFF, 8'h00, 2);
    add_vec("zero_neg",   1'b1, 1'b1, 1'b0,  0, 0, 8'h00, 8'h00, 2);
    add_vec("nar",        1'b0, 1'b0, 1'b1,  0, 0, 8'h00, 8'h80, 2);
    add_vec("nar_zero",   1'b1, 1'b1, 1'b1,  2, 1, 8'h55, 8'h80, 2);
    add_vec("round_odd",  1'b0, 1'b0, 1'b0,  0, 0, 8'h18, RND_A, 8);
    add_vec("tie_even",   1'b0, 1'b0, 1'b0,  0, 0, 8'h08, 8'h40, 8);
    add_vec("round_carry",1'b0, 1'b0, 1'b0,  0, 1, 8'hFC, RND_B, 8);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      pack(vecs[i].s, vecs[i].z, vecs[i].n, vecs[i].k, vecs[i].e, vecs[i].f, d, lat);
      check({vecs[i].name, "_data"}, 32'(d), 32'(vecs[i].exp_d));
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
    end
    prev = vecs[vecs.size() - 1].exp_d;

    // Backpressure: result held in DONE, no new accept while stalled.
    set_op(1'b0, 1'b0, 1'b0, 0, 1, 8'h80);
    in_valid = 1'b1;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    check("hold_prev_during_pack", 32'(out_data), 32'(prev));
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int c = 0; c < 5; c++) begin
      check("stall_data", 32'(out_data), 32'h58);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("retire_out_valid", 32'(out_valid), 32'd0);
    check("retire_in_ready", 32'(in_ready), 32'd1);
    hits = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) hits++;
    end
    check("single_retirement", 32'(hits), 32'd0);

    // Reset pulse mid-REGIME discards the operand.
    set_op(1'b1, 1'b0, 1'b0, 2, 1, 8'hC3);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) hits++;
    end
    check("midreset_no_valid", 32'(hits), 32'd0);
    pack(1'b0, 1'b0, 1'b0, 0, 1, 8'h80, d, lat);
    check("after_reset_data", 32'(d), 32'h58);
    check("after_reset_lat", 32'(lat), 32'd8);

    // Random operands against the stream model.
    for (int r = 0; r < 150; r++) begin
      s = 1'($urandom_range(0, 1));
      z = ($urandom_range(0, 15) == 0);
      n = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        k = int'($signed(8'($urandom_range(0, 255))));
      end else begin
        k = int'($urandom_range(0, 16)) - 8;
      end
      e = int'($urandom_range(0, 1));
      f = int'($urandom_range(0, 255));
      pack(s, z, n, k, e, f, d, lat);
      check("rand_data", 32'(d), 32'(ref_pack(s, z, n, k, e, f)));
      check("rand_lat", 32'(lat), (z || n) ? 32'd2 : 32'd8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
